// File: rtl/spectrum_portb_ctrl.sv
// spectrum_portb_ctrl
// Owns port B of the dual-port spectrum RAM and runs three jobs on it:
// clear sweep, single-channel host read and a streamed full-spectrum dump.
// Optional dump path is built only when SPECTRUM_DUMP_EN is defined.
// Handshake: a dump beat transfers on a rising clock edge where dump_valid
// and dump_ready are both high; while dump_valid=1 and dump_ready=0 the
// beat (dump_data/dump_addr/dump_last) is held unchanged.
module spectrum_portb_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 2
) (
    input  logic              CLOCK_65,
    input  logic              rst,
    input  logic              acq_active,
    input  logic              clr_req,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              dump_req,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_last,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy,
    output logic              clr_done,
    output logic              clr_err,
    output logic [2:0]        o_dbg_state
);

    localparam int LAT_W = $clog2(READ_LAT + 1);
    localparam logic [LAT_W-1:0]  LAT_MAX = LAT_W'(READ_LAT);
    localparam logic [ADDR_W-1:0] LAST    = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RD_WAIT, S_DUMP_ISSUE, S_DUMP_WAIT, S_DUMP_HOLD
    } state_t;

    state_t            r_state, w_nxt_state;
    logic              r_clr_pend;
    logic [LAT_W-1:0]  r_lat, w_nxt_lat;
    logic [ADDR_W-1:0] r_ram_address, w_nxt_address;
    logic              r_ram_wren, w_nxt_wren;
    logic              r_rd_ack, w_nxt_rd_ack;
    logic              r_rd_valid, w_nxt_rd_valid;
    logic [DATA_W-1:0] r_rd_data, w_nxt_rd_data;
    logic              r_busy;
    logic              r_clr_done, w_nxt_clr_done;
    logic              r_clr_err, w_nxt_clr_err;
    logic              w_clr_any, w_clr_take;

`ifdef SPECTRUM_DUMP_EN
    logic              r_dump_pend, w_dump_any, w_dump_take;
    logic [ADDR_W-1:0] r_dump_cnt, w_nxt_cnt;
    logic              r_dump_valid, w_nxt_dvalid;
    logic [DATA_W-1:0] r_dump_data, w_nxt_ddata;
    logic [ADDR_W-1:0] r_dump_addr, w_nxt_daddr;
    logic              r_dump_last, w_nxt_dlast;
    assign w_dump_any = r_dump_pend | dump_req;
`else
    logic w_unused;
    assign w_unused = &{1'b0, dump_req, dump_ready};
`endif

    // A request pulse counts in the same cycle it arrives, not only once latched.
    assign w_clr_any = r_clr_pend | clr_req;

    // Next-state and next-output decode; every register has a default first.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_lat      = r_lat;
        w_nxt_address  = r_ram_address;
        w_nxt_wren     = 1'b0;
        w_nxt_rd_ack   = 1'b0;
        w_nxt_rd_valid = 1'b0;
        w_nxt_rd_data  = r_rd_data;
        w_nxt_clr_done = 1'b0;
        w_nxt_clr_err  = 1'b0;
        w_clr_take     = 1'b0;
`ifdef SPECTRUM_DUMP_EN
        w_dump_take    = 1'b0;
        w_nxt_cnt      = r_dump_cnt;
        w_nxt_dvalid   = r_dump_valid;
        w_nxt_ddata    = r_dump_data;
        w_nxt_daddr    = r_dump_addr;
        w_nxt_dlast    = r_dump_last;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_clr_any) begin
                    w_clr_take = 1'b1;
                    if (acq_active) begin
                        w_nxt_clr_err = 1'b1;
                    end else begin
                        w_nxt_state   = S_CLEAR;
                        w_nxt_address = '0;
                        w_nxt_wren    = 1'b1;
                    end
                end else if (rd_req) begin
                    w_nxt_state   = S_RD_WAIT;
                    w_nxt_rd_ack  = 1'b1;
                    w_nxt_address = rd_addr;
                    w_nxt_lat     = '0;
                end
`ifdef SPECTRUM_DUMP_EN
                else if (w_dump_any) begin
                    w_dump_take   = 1'b1;
                    w_nxt_state   = S_DUMP_ISSUE;
                    w_nxt_address = '0;
                    w_nxt_cnt     = '0;
                    w_nxt_lat     = '0;
                end
`endif
            end
            S_CLEAR: begin
                // Terminate on the last index, not on counter wrap.
                if (r_ram_address == LAST) begin
                    w_nxt_state    = S_IDLE;
                    w_nxt_clr_done = 1'b1;
                end else begin
                    w_nxt_address = r_ram_address + 1'b1;
                    w_nxt_wren    = 1'b1;
                end
            end
            S_RD_WAIT: begin
                if (r_lat == LAT_MAX) begin
                    w_nxt_rd_data  = ram_q;
                    w_nxt_rd_valid = 1'b1;
                    w_nxt_state    = S_IDLE;
                end else begin
                    w_nxt_lat = r_lat + 1'b1;
                end
            end
`ifdef SPECTRUM_DUMP_EN
            S_DUMP_ISSUE: begin
                // The issue cycle is the first of the READ_LAT wait cycles.
                w_nxt_lat   = r_lat + 1'b1;
                w_nxt_state = S_DUMP_WAIT;
            end
            S_DUMP_WAIT: begin
                if (r_lat == LAT_MAX) begin
                    w_nxt_ddata  = ram_q;
                    w_nxt_daddr  = r_dump_cnt;
                    w_nxt_dlast  = (r_dump_cnt == LAST);
                    w_nxt_dvalid = 1'b1;
                    w_nxt_state  = S_DUMP_HOLD;
                end else begin
                    w_nxt_lat = r_lat + 1'b1;
                end
            end
            S_DUMP_HOLD: begin
                if (dump_ready) begin
                    w_nxt_dvalid = 1'b0;
                    w_nxt_dlast  = 1'b0;
                    if (r_dump_cnt == LAST) begin
                        w_nxt_state = S_IDLE;
                    end else begin
                        w_nxt_cnt     = r_dump_cnt + 1'b1;
                        w_nxt_address = r_dump_cnt + 1'b1;
                        w_nxt_lat     = '0;
                        w_nxt_state   = S_DUMP_ISSUE;
                    end
                end
            end
`endif
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // State and registered outputs; busy also covers the job's final pulse cycle.
    always_ff @(posedge CLOCK_65) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_clr_pend    <= 1'b0;
            r_lat         <= '0;
            r_ram_address <= '0;
            r_ram_wren    <= 1'b0;
            r_rd_ack      <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_data     <= '0;
            r_busy        <= 1'b0;
            r_clr_done    <= 1'b0;
            r_clr_err     <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_clr_pend    <= w_clr_any & ~w_clr_take;
            r_lat         <= w_nxt_lat;
            r_ram_address <= w_nxt_address;
            r_ram_wren    <= w_nxt_wren;
            r_rd_ack      <= w_nxt_rd_ack;
            r_rd_valid    <= w_nxt_rd_valid;
            r_rd_data     <= w_nxt_rd_data;
            r_busy        <= (w_nxt_state != S_IDLE) | w_nxt_rd_valid | w_nxt_clr_done;
            r_clr_done    <= w_nxt_clr_done;
            r_clr_err     <= w_nxt_clr_err;
        end
    end

`ifdef SPECTRUM_DUMP_EN
    // Dump pending flag, channel counter and the held output beat.
    always_ff @(posedge CLOCK_65) begin
        if (rst) begin
            r_dump_pend  <= 1'b0;
            r_dump_cnt   <= '0;
            r_dump_valid <= 1'b0;
            r_dump_data  <= '0;
            r_dump_addr  <= '0;
            r_dump_last  <= 1'b0;
        end else begin
            r_dump_pend  <= w_dump_any & ~w_dump_take;
            r_dump_cnt   <= w_nxt_cnt;
            r_dump_valid <= w_nxt_dvalid;
            r_dump_data  <= w_nxt_ddata;
            r_dump_addr  <= w_nxt_daddr;
            r_dump_last  <= w_nxt_dlast;
        end
    end
    assign dump_valid = r_dump_valid;
    assign dump_data  = r_dump_data;
    assign dump_addr  = r_dump_addr;
    assign dump_last  = r_dump_last;
`else
    assign dump_valid = 1'b0;
    assign dump_data  = '0;
    assign dump_addr  = '0;
    assign dump_last  = 1'b0;
`endif

    assign ram_address = r_ram_address;
    assign ram_data    = '0;
    assign ram_wren    = r_ram_wren;
    assign rd_ack      = r_rd_ack;
    assign rd_valid    = r_rd_valid;
    assign rd_data     = r_rd_data;
    assign busy        = r_busy;
    assign clr_done    = r_clr_done;
    assign clr_err     = r_clr_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spectrum_portb_ctrl.sv
// Bench for spectrum_portb_ctrl: behavioural RAM, reference memory contents,
// randomized reads, clear/priority sequence, reset abort and the dump stream
// (or its absence when SPECTRUM_DUMP_EN is not defined).
module tb_spectrum_portb_ctrl;

  localparam int N = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, acq_active, clr_req, rd_req, dump_req, dump_ready;
  logic [9:0]  rd_addr;
  logic        rd_ack, rd_valid, dump_valid, dump_last, ram_wren;
  logic        busy, clr_done, clr_err;
  logic [31:0] rd_data, dump_data, ram_data, ram_q;
  logic [9:0]  dump_addr, ram_address;
  logic [2:0]  dbg_state;

  spectrum_portb_ctrl dut (
    .CLOCK_65(clk), .rst(rst), .acq_active(acq_active), .clr_req(clr_req),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid),
    .rd_data(rd_data), .dump_req(dump_req), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_data(dump_data), .dump_addr(dump_addr),
    .dump_last(dump_last), .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q), .busy(busy), .clr_done(clr_done),
    .clr_err(clr_err), .o_dbg_state(dbg_state)
  );

  // ---------------- RAM port B model, 2-cycle read latency ----------------
  logic [31:0] mem [N];
  logic [9:0]  ram_a1;
  logic        preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < N; i++) mem[i] <= 32'(i + 1);
    end else if (ram_wren) begin
      mem[ram_address] <= ram_data;
    end
    ram_a1 <= ram_address;
    ram_q  <= mem[ram_a1];
  end

  // ---------------- reference contents and scoreboard ----------------
  logic [31:0] exp_mem [N];
  logic [31:0] exp_q [$];
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_flags"}, 64'({rd_ack, rd_valid, busy, clr_done, clr_err, ram_wren, dump_valid, dump_last}), 64'd0);
    check({tag, "_ram_addr"}, 64'(ram_address), 64'd0);
    check({tag, "_ram_data"}, 64'(ram_data), 64'd0);
    check({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    check({tag, "_dump_bus"}, 64'({dump_addr, dump_data}), 64'd0);
  endtask

  // Single read from IDLE: ack next cycle, data three cycles after the ack.
  task automatic do_read(input logic [9:0] a);
    int k;
    logic [31:0] e;
    rd_req = 1'b1;
    rd_addr = a;
    exp_q.push_back(exp_mem[a]);
    tick();
    check("rd_ack", 64'(rd_ack), 64'd1);
    check("rd_ram_addr", 64'(ram_address), 64'(a));
    check("rd_busy", 64'(busy), 64'd1);
    rd_req = 1'b0;
    rd_addr = 10'($urandom);
    k = 0;
    while (!rd_valid && k < 10) begin
      tick();
      k++;
    end
    check("rd_latency", 64'(k), 64'd3);
    e = exp_q.pop_front();
    check("rd_data", 64'(rd_data), 64'(e));
    check("rd_busy_last", 64'(busy), 64'd1);
    tick();
    check("rd_hold", 64'({rd_valid, busy, rd_data}), 64'({2'b00, e}));
  endtask

`ifdef SPECTRUM_DUMP_EN
  // Stream consumer; call in the cycle the dump is accepted.
  task automatic run_dump(input int pct, input int abort_at);
    int cyc, beats;
    bit done, stalled, seen;
    logic [63:0] snap;
    cyc = 0; beats = 0; done = 0; stalled = 0; seen = 0; snap = '0;
    while (!done && cyc < 20000) begin
      tick();
      cyc++;
      dump_req = 1'b0;
      if (stalled) check("dump_stable", 64'({dump_valid, dump_last, dump_addr, dump_data}), snap);
      stalled = 0;
      if (dump_valid) begin
        if (!seen) check("dump_first_lat", 64'(cyc), 64'd4);
        seen = 1;
        if ($urandom_range(0, 99) < pct) begin
          check("dump_addr", 64'(dump_addr), 64'(beats));
          check("dump_data", 64'(dump_data), 64'(exp_mem[beats]));
          check("dump_last", 64'(dump_last), 64'(beats == N - 1));
          dump_ready = 1'b1;
          beats++;
          if (beats == N) done = 1;
          else if (beats == abort_at) begin
            rst = 1'b1;
            done = 1;
          end
        end else begin
          dump_ready = 1'b0;
          stalled = 1;
          snap = 64'({dump_valid, dump_last, dump_addr, dump_data});
        end
      end else begin
        dump_ready = 1'($urandom_range(0, 1));
      end
    end
    if (!done) check("dump_timeout", 64'd0, 64'd1);
    tick();
    dump_ready = 1'b0;
    if (rst) begin
      rst = 1'b0;
      check_reset("dump_abort");
      begin
        logic any_v;
        any_v = 0;
        for (int i = 0; i < 20; i++) begin
          tick();
          any_v |= dump_valid | busy;
        end
        check("dump_abort_quiet", 64'(any_v), 64'd0);
      end
    end else begin
      check("dump_end", 64'({busy, dump_valid, dump_last}), 64'd0);
    end
  endtask
`endif

  // ---------------- main sequence ----------------
  initial begin
    logic [9:0] a;
    logic seen;
    rst = 1'b1; preload = 1'b1;
    acq_active = 0; clr_req = 0; rd_req = 0; dump_req = 0; dump_ready = 0; rd_addr = '0;
    for (int i = 0; i < N; i++) exp_mem[i] = 32'(i + 1);
    tick();
    preload = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check_reset("reset");

    // directed read of 0x155 -> 0x156
    do_read(10'h155);

    // random reads with random idle gaps
    for (int i = 0; i < 16; i++) begin
      do_read(10'($urandom_range(0, N - 1)));
      repeat ($urandom_range(0, 3)) tick();
    end
    do_read(10'h3FF);
    do_read(10'h000);

`ifdef SPECTRUM_DUMP_EN
    dump_req = 1'b1;
    run_dump(30, 0);
`endif

    // refused clear: error pulse, no writes, request dropped
    acq_active = 1'b1;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("clr_err", 64'({clr_err, busy, ram_wren}), 64'b100);
    acq_active = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen |= ram_wren | clr_done | clr_err | busy;
    end
    check("clr_refused_quiet", 64'(seen), 64'd0);

    // same-cycle clear, read and dump: clear, then read, then dump
    a = 10'($urandom_range(1, N - 2));
    clr_req = 1'b1; dump_req = 1'b1; rd_req = 1'b1; rd_addr = a;
    tick();
    clr_req = 1'b0; dump_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      check("clr_write", 64'({rd_ack, ram_wren, ram_address, ram_data}), 64'({2'b01, 10'(i), 32'd0}));
      acq_active = 1'($urandom_range(0, 1));
      tick();
    end
    acq_active = 1'b0;
    check("clr_done", 64'({ram_wren, clr_done, busy, rd_ack}), 64'b0110);
    for (int i = 0; i < N; i++) exp_mem[i] = 32'd0;
    tick();
    check("prio_rd_ack", 64'({rd_ack, ram_address}), 64'({1'b1, a}));
    rd_req = 1'b0;
    tick(); tick(); tick();
    check("prio_rd_data", 64'({rd_valid, rd_data}), 64'({1'b1, 32'd0}));
`ifdef SPECTRUM_DUMP_EN
    run_dump(50, 0);
`else
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= busy | dump_valid;
    end
    check("prio_no_dump", 64'(seen), 64'd0);
`endif
    do_read(10'h000);
    do_read(10'h3FF);

    // reset in the middle of a read
    rd_req = 1'b1; rd_addr = 10'h0AA;
    tick();
    rd_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("mid_rd");
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen |= rd_valid | busy;
    end
    check("mid_rd_quiet", 64'(seen), 64'd0);
    do_read(10'($urandom_range(0, N - 1)));

`ifdef SPECTRUM_DUMP_EN
    dump_req = 1'b1;
    run_dump(70, 500);
    do_read(10'($urandom_range(0, N - 1)));
`else
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      dump_ready = 1'($urandom_range(0, 1));
      tick();
      seen |= busy | dump_valid | dump_last;
    end
    check("dump_disabled", 64'(seen), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
